// File: rtl/rpm_pkg.sv
// rpm_pkg: shared definitions for the tachometer pulse generator.
//   RPM_CNT_W      - default width of period/high counters and config fields
//   RPM_MIN_PERIOD - default smallest legal period in clk cycles
//   rpm_state_t    - generator FSM states
//   rpm_cfg_t      - one period/high configuration pair at the default width
package rpm_pkg;

  localparam int RPM_CNT_W      = 32;
  localparam int RPM_MIN_PERIOD = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } rpm_state_t;

  typedef struct packed {
    logic [RPM_CNT_W-1:0] period;
    logic [RPM_CNT_W-1:0] high;
  } rpm_cfg_t;

endpackage

// File: rtl/rpm_cfg_shadow.sv
// rpm_cfg_shadow: configuration handshake, legality check and the
// shadow/active register pair of the pulse generator.
// Ports:
//   clk, rst_n                  - clock, asynchronous active-low reset
//   cfg_period, cfg_high        - offered configuration
//   cfg_valid / cfg_ready       - offer handshake; cfg_ready means shadow empty
//   cfg_err                     - one-cycle strobe: accepted offer was illegal
//   apply                       - from the FSM: move shadow into active now
//   shadow_full                 - shadow holds a pending legal config
//   active_valid                - active config has been loaded since reset
//   active_period, active_high  - configuration currently driving the output
module rpm_cfg_shadow #(
  parameter int CNT_W      = 32,
  parameter int MIN_PERIOD = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             cfg_err,
  input  logic             apply,
  output logic             shadow_full,
  output logic             active_valid,
  output logic [CNT_W-1:0] active_period,
  output logic [CNT_W-1:0] active_high
);

  logic             accept;
  logic             legal;
  logic [CNT_W-1:0] shadow_period;
  logic [CNT_W-1:0] shadow_high;

  assign cfg_ready = ~shadow_full;
  assign accept    = cfg_valid & cfg_ready;
  assign legal     = (cfg_period >= CNT_W'(MIN_PERIOD)) &&
                     (cfg_high != '0) &&
                     (cfg_high < cfg_period);

  // Accept and apply are mutually exclusive (accept needs an empty shadow,
  // apply a full one), so an offer taken on a boundary cycle can never be
  // applied on that same boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_full  <= 1'b0;
      active_valid <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      cfg_err <= accept & ~legal;
      if (accept && legal) begin
        shadow_full <= 1'b1;
      end else if (apply) begin
        shadow_full  <= 1'b0;
        active_valid <= 1'b1;
      end
    end
  end

  // Config data needs no reset: it is qualified by shadow_full/active_valid.
  always_ff @(posedge clk) begin
    if (accept && legal) begin
      shadow_period <= cfg_period;
      shadow_high   <= cfg_high;
    end
    if (apply) begin
      active_period <= shadow_period;
      active_high   <= shadow_high;
    end
  end

endmodule

// File: rtl/rpm_pulse_gen.sv
// rpm_pulse_gen: programmable tachometer pulse generator. Emits a pulse train
// whose rising edges are exactly active_period clk cycles apart with a high
// time of exactly active_high cycles. New configuration is double-buffered
// and only takes effect on a period boundary, so no runt pulses occur.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   enable                - level-sensitive run request (graceful stop on drop)
//   cfg_period, cfg_high  - offered configuration
//   cfg_valid / cfg_ready - offer handshake
//   cfg_err               - one-cycle strobe: offered config rejected
//   rpm_out               - registered pulse train
//   period_start          - one-cycle strobe with each rpm_out rising edge
//   busy                  - generator not idle
//   pulse_count           - only with RPM_GEN_PULSE_CNT_EN defined: count of
//                           period starts, wraps, holds while idle
module rpm_pulse_gen
  import rpm_pkg::*;
#(
  parameter int CNT_W      = RPM_CNT_W,
  parameter int MIN_PERIOD = RPM_MIN_PERIOD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             rpm_out,
  output logic             period_start,
  output logic             busy
`ifdef RPM_GEN_PULSE_CNT_EN
  ,
  output logic [CNT_W-1:0] pulse_count
`endif
);

  rpm_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rpm_d;
  logic             ps_d;
  logic             apply;
  logic             boundary;
  logic             shadow_full;
  logic             active_valid;
  logic [CNT_W-1:0] active_period;
  logic [CNT_W-1:0] active_high;

  rpm_cfg_shadow #(
    .CNT_W      (CNT_W),
    .MIN_PERIOD (MIN_PERIOD)
  ) u_cfg (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_period    (cfg_period),
    .cfg_high      (cfg_high),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_err       (cfg_err),
    .apply         (apply),
    .shadow_full   (shadow_full),
    .active_valid  (active_valid),
    .active_period (active_period),
    .active_high   (active_high)
  );

  assign boundary = (cnt_q == active_period - 1'b1);
  assign busy     = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rpm_out      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rpm_out      <= rpm_d;
      period_start <= ps_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable && active_valid) state_d = RUN;
      RUN:     if (boundary && !enable)    state_d = STOP;
      STOP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next-cycle outputs. rpm_out is registered from the next count value; when
  // the count wraps to 0 the output is always high because any legal high
  // time is at least one cycle, whichever config is applied at that edge.
  always_comb begin
    cnt_d = '0;
    rpm_d = 1'b0;
    ps_d  = 1'b0;
    apply = 1'b0;
    case (state_q)
      IDLE: begin
        apply = shadow_full;
        if (state_d == RUN) begin
          rpm_d = 1'b1;
          ps_d  = 1'b1;
        end
      end
      RUN: begin
        if (boundary) begin
          apply = shadow_full;
          if (enable) begin
            rpm_d = 1'b1;
            ps_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          rpm_d = (cnt_d < active_high);
        end
      end
      default: ;
    endcase
  end

`ifdef RPM_GEN_PULSE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_count <= '0;
    end else if (ps_d) begin
      pulse_count <= pulse_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rpm_pulse_gen.sv
// tb_rpm_pulse_gen: directed self-checking bench for rpm_pulse_gen.
// Covers reset state, steady pulse train, mid-period reconfiguration,
// illegal offers, graceful stop, asynchronous reset and a 100/40 loopback
// measurement. Honors RPM_GEN_PULSE_CNT_EN for the pulse_count output.
module tb_rpm_pulse_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [31:0] cfg_period;
  logic [31:0] cfg_high;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        cfg_err;
  logic        rpm_out;
  logic        period_start;
  logic        busy;
`ifdef RPM_GEN_PULSE_CNT_EN
  logic [31:0] pulse_count;
`endif

  int checks = 0;
  int errors = 0;

  rpm_pulse_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .cfg_period   (cfg_period),
    .cfg_high     (cfg_high),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_err      (cfg_err),
    .rpm_out      (rpm_out),
    .period_start (period_start),
    .busy         (busy)
`ifdef RPM_GEN_PULSE_CNT_EN
    ,
    .pulse_count  (pulse_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic offer(input int p, input int h);
    cfg_period = p;
    cfg_high   = h;
    cfg_valid  = 1'b1;
  endtask

  // Tick n times; position (start+i) mod per in a period with high time hi.
  task automatic run_chk(input int n, input int per, input int hi, input int start);
    for (int i = 0; i < n; i++) begin
      int pos;
      tick();
      pos = (start + i) % per;
      chk("rpm_out", {31'd0, rpm_out}, (pos < hi) ? 32'd1 : 32'd0);
      chk("period_start", {31'd0, period_start}, (pos == 0) ? 32'd1 : 32'd0);
      chk("busy_run", {31'd0, busy}, 32'd1);
    end
  endtask

  initial begin
    int  len;
    int  hi;
    bit  rose;
    logic prev;

    rst_n = 1'b0; enable = 1'b0; cfg_valid = 1'b0;
    cfg_period = '0; cfg_high = '0;
    tick(); tick();
    chk("rst_rpm_out", {31'd0, rpm_out}, 32'd0);
    chk("rst_period_start", {31'd0, period_start}, 32'd0);
    chk("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    rst_n = 1'b1;
    tick();
    chk("idle_rpm_out", {31'd0, rpm_out}, 32'd0);

    // Basic 10/3 train; first rise one cycle after active config + enable.
    enable = 1'b1;
    offer(10, 3);
    tick();
    cfg_valid = 1'b0;
    chk("t1_ready_low", {31'd0, cfg_ready}, 32'd0);
    chk("t1_rpm_pre", {31'd0, rpm_out}, 32'd0);
    tick();
    chk("t1_ready_back", {31'd0, cfg_ready}, 32'd1);
    chk("t1_rpm_apply", {31'd0, rpm_out}, 32'd0);
    chk("t1_busy_apply", {31'd0, busy}, 32'd0);
    run_chk(23, 10, 3, 0);

    // Mid-period offer 6/2 at cnt=2: current period stays 10.
    offer(6, 2);
    run_chk(1, 10, 3, 3);
    cfg_valid = 1'b0;
    chk("t2_ready_low", {31'd0, cfg_ready}, 32'd0);
    run_chk(6, 10, 3, 4);
    chk("t2_ready_boundary", {31'd0, cfg_ready}, 32'd0);
    run_chk(1, 6, 2, 0);
    chk("t2_ready_after", {31'd0, cfg_ready}, 32'd1);
    run_chk(11, 6, 2, 1);

    // Illegal offers: high == period, then period < MIN and high == 0.
    offer(5, 5);
    run_chk(1, 6, 2, 0);
    cfg_valid = 1'b0;
    chk("t3_err_a", {31'd0, cfg_err}, 32'd1);
    chk("t3_ready_a", {31'd0, cfg_ready}, 32'd1);
    run_chk(1, 6, 2, 1);
    chk("t3_err_a_off", {31'd0, cfg_err}, 32'd0);
    offer(1, 0);
    run_chk(1, 6, 2, 2);
    cfg_valid = 1'b0;
    chk("t3_err_b", {31'd0, cfg_err}, 32'd1);
    run_chk(1, 6, 2, 3);
    chk("t3_err_b_off", {31'd0, cfg_err}, 32'd0);
    chk("t3_ready_b", {31'd0, cfg_ready}, 32'd1);
    run_chk(8, 6, 2, 4);

    // Offer 8/3 on the boundary cycle: pending for one more 6-period.
    offer(8, 3);
    run_chk(1, 6, 2, 0);
    cfg_valid = 1'b0;
    chk("t4_ready_pend", {31'd0, cfg_ready}, 32'd0);
    run_chk(5, 6, 2, 1);
    run_chk(1, 8, 3, 0);
    chk("t4_ready_after", {31'd0, cfg_ready}, 32'd1);
    run_chk(2, 8, 3, 1);
    // Drop enable at cnt=2: period completes, one STOP cycle, then idle.
    enable = 1'b0;
    run_chk(5, 8, 3, 3);
    tick();
    chk("t4_stop_rpm", {31'd0, rpm_out}, 32'd0);
    chk("t4_stop_ps", {31'd0, period_start}, 32'd0);
    chk("t4_stop_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("t4_idle_busy", {31'd0, busy}, 32'd0);
    chk("t4_idle_rpm", {31'd0, rpm_out}, 32'd0);
    tick();
    chk("t4_idle_rpm2", {31'd0, rpm_out}, 32'd0);

    // Async reset while high; config is lost afterwards.
    enable = 1'b1;
    tick();
    chk("t5_rpm_high", {31'd0, rpm_out}, 32'd1);
    chk("t5_ps_high", {31'd0, period_start}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_rpm", {31'd0, rpm_out}, 32'd0);
    chk("t5_async_busy", {31'd0, busy}, 32'd0);
    chk("t5_async_ready", {31'd0, cfg_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_noconfig_rpm", {31'd0, rpm_out}, 32'd0);
      chk("t5_noconfig_busy", {31'd0, busy}, 32'd0);
    end
    offer(4, 1);
    tick();
    cfg_valid = 1'b0;
    tick();
    tick();
    chk("t5_restart_rpm", {31'd0, rpm_out}, 32'd1);
    chk("t5_restart_ps", {31'd0, period_start}, 32'd1);
    run_chk(7, 4, 1, 1);

    // Loopback measurement at 100/40 over five periods.
    enable = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    enable = 1'b1;
    offer(100, 40);
    tick();
    cfg_valid = 1'b0;
    rose = 1'b0;
    for (int c = 0; c < 10 && !rose; c++) begin
      tick();
      if (rpm_out) rose = 1'b1;
    end
    chk("t6_first_rise", {31'd0, rpm_out}, 32'd1);
    chk("t6_first_ps", {31'd0, period_start}, 32'd1);
`ifdef RPM_GEN_PULSE_CNT_EN
    chk("t6_pulse_count_1", pulse_count, 32'd1);
`endif
    for (int k = 0; k < 5; k++) begin
      len  = 0;
      hi   = 1;
      prev = 1'b1;
      rose = 1'b0;
      for (int c = 0; c < 200 && !rose; c++) begin
        tick();
        len++;
        if (!prev && rpm_out) rose = 1'b1;
        else if (rpm_out) hi++;
        prev = rpm_out;
      end
      chk("t6_period", len, 32'd100);
      chk("t6_high", hi, 32'd40);
      chk("t6_ps_rise", {31'd0, period_start}, 32'd1);
`ifdef RPM_GEN_PULSE_CNT_EN
      chk("t6_pulse_count", pulse_count, 32'(k + 2));
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
